sdram_burst_arbiter: RTL and testbench

//  Schedules full-page (512-word) bursts on the single-port SDRAM controller for three streams:

---
 rtl/sdram_arb_pkg.sv | 20 ++
 rtl/sdram_arb_blkptr.sv | 29 ++
 rtl/sdram_burst_arbiter.sv | 222 ++++++++++++++++++++++
 tb/tb_sdram_burst_arbiter.sv | 304 ++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/sdram_arb_pkg.sv
// Shared definitions for the SDRAM burst arbiter: FSM states, burst owner
// codes and read/write command codes.
package sdram_arb_pkg;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    CMD  = 2'd1,
    HOLD = 2'd2,
    BUSY = 2'd3
  } arb_state_e;

  localparam logic [1:0] SRC_NONE = 2'd0;
  localparam logic [1:0] SRC_CAM  = 2'd1;
  localparam logic [1:0] SRC_EDGE = 2'd2;
  localparam logic [1:0] SRC_VGA  = 2'd3;

  localparam logic RW_WR = 1'b0;
  localparam logic RW_RD = 1'b1;

endpackage

// File: rtl/sdram_arb_blkptr.sv
// Block pointer with frame wrap: counts BASE .. BASE+LEN-1 and back to BASE.
// clear forces the pointer to BASE and wins over a coincident advance.
module sdram_arb_blkptr #(
  parameter int AW   = 15,
  parameter int BASE = 0,
  parameter int LEN  = 600
) (
  input  logic          clk,
  input  logic          rst_n,
  input  logic          advance,
  input  logic          clear,
  output logic [AW-1:0] ptr
);

  localparam logic [AW-1:0] FIRST = AW'(BASE);
  localparam logic [AW-1:0] LAST  = AW'(BASE + LEN - 1);

  // Pointer register: clear to base, otherwise step with wrap on advance
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      ptr <= FIRST;
    end else if (clear) begin
      ptr <= FIRST;
    end else if (advance) begin
      ptr <= (ptr == LAST) ? FIRST : ptr + 1'b1;
    end
  end

endmodule

// File: rtl/sdram_burst_arbiter.sv
// SDRAM full-page burst arbiter for camera write, Sobel edge write and VGA
// read-back streams. Drives the rw/rw_en/f_addr command handshake of the
// controller and reports the active burst owner on src_sel.
// Optional build macro ARB_STATS_EN adds grant counters and a VGA starvation
// counter as extra output ports.
module sdram_burst_arbiter
  import sdram_arb_pkg::*;
#(
  parameter int AW        = 15,
  parameter int CW        = 10,
  parameter int BLK_FRAME = 600,
  parameter int RAW_BASE  = 0,
  parameter int EDGE_BASE = 600,
  parameter int WR_THRESH = 512,
  parameter int VGA_LOW   = 250,
  parameter int AGE_MAX   = 8,
  parameter int HOLDOFF   = 2
) (
  input  logic          clk,
  input  logic          rst_n,
  input  logic          ready,
  input  logic [CW-1:0] cam_count,
  input  logic [CW-1:0] edge_count,
  input  logic [CW-1:0] vga_count,
  input  logic          vga_frame_start,
  input  logic          sobel_sel,
  output logic          rw_en,
  output logic          rw,
  output logic [AW-1:0] f_addr,
  output logic [1:0]    src_sel,
  output logic          busy,
  output logic          disp_sobel
`ifdef ARB_STATS_EN
  ,
  output logic [31:0]   gnt_cam,
  output logic [31:0]   gnt_edge,
  output logic [31:0]   gnt_vga,
  output logic [15:0]   vga_starve
`endif
);

  localparam int AGEW = $clog2(AGE_MAX + 1);
  localparam int HCW  = (HOLDOFF > 1) ? $clog2(HOLDOFF) : 1;

  localparam logic [AGEW-1:0] AGE_SAT   = AGEW'(AGE_MAX);
  localparam logic [HCW-1:0]  HOLD_LAST = HCW'(HOLDOFF - 1);
  localparam logic [CW-1:0]   WR_LIM    = CW'(WR_THRESH - 1);
  localparam logic [CW-1:0]   RD_LIM    = CW'(VGA_LOW);
  localparam logic [AW-1:0]   RAW_A     = AW'(RAW_BASE);
  localparam logic [AW-1:0]   EDGE_A    = AW'(EDGE_BASE);

  arb_state_e      state;
  logic [HCW-1:0]  hold_cnt;
  logic [AGEW-1:0] age_cam;
  logic [AGEW-1:0] age_edge;

  logic            cam_req;
  logic            edge_req;
  logic            vga_req;
  logic            grant;
  logic [1:0]      win;
  logic [AW-1:0]   win_addr;
  logic [AW-1:0]   cam_ptr;
  logic [AW-1:0]   edge_ptr;
  logic [AW-1:0]   vga_off;

  assign cam_req  = (cam_count > WR_LIM);
  assign edge_req = (edge_count > WR_LIM);
  assign vga_req  = (vga_count < RD_LIM);
  assign grant    = (state == IDLE) && ready && (cam_req || edge_req || vga_req);

  // Winner selection: VGA read, then aged writes (cam first), then cam, then edge
  always_comb begin
    win = SRC_NONE;
    if (vga_req) begin
      win = SRC_VGA;
    end else if (cam_req && (age_cam == AGE_SAT)) begin
      win = SRC_CAM;
    end else if (edge_req && (age_edge == AGE_SAT)) begin
      win = SRC_EDGE;
    end else if (cam_req) begin
      win = SRC_CAM;
    end else if (edge_req) begin
      win = SRC_EDGE;
    end
  end

  // Block address of the winning stream; VGA reads the displayed region
  always_comb begin
    win_addr = '0;
    case (win)
      SRC_CAM:  win_addr = cam_ptr;
      SRC_EDGE: win_addr = edge_ptr;
      SRC_VGA:  win_addr = vga_off + (disp_sobel ? EDGE_A : RAW_A);
      default:  win_addr = '0;
    endcase
  end

  sdram_arb_blkptr #(.AW(AW), .BASE(RAW_BASE), .LEN(BLK_FRAME)) u_cam_ptr (
    .clk     (clk),
    .rst_n   (rst_n),
    .advance (grant && (win == SRC_CAM)),
    .clear   (1'b0),
    .ptr     (cam_ptr)
  );

  sdram_arb_blkptr #(.AW(AW), .BASE(EDGE_BASE), .LEN(BLK_FRAME)) u_edge_ptr (
    .clk     (clk),
    .rst_n   (rst_n),
    .advance (grant && (win == SRC_EDGE)),
    .clear   (1'b0),
    .ptr     (edge_ptr)
  );

  // Frame start wins over a coincident grant so the offset lands on 0, not 1
  sdram_arb_blkptr #(.AW(AW), .BASE(0), .LEN(BLK_FRAME)) u_vga_ptr (
    .clk     (clk),
    .rst_n   (rst_n),
    .advance (grant && (win == SRC_VGA)),
    .clear   (vga_frame_start),
    .ptr     (vga_off)
  );

  // Write aging: losers that are pending gain age, the winner restarts at 0
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      age_cam  <= '0;
      age_edge <= '0;
    end else if (grant) begin
      if (win == SRC_CAM) begin
        age_cam <= '0;
      end else if (cam_req && (age_cam != AGE_SAT)) begin
        age_cam <= age_cam + 1'b1;
      end
      if (win == SRC_EDGE) begin
        age_edge <= '0;
      end else if (edge_req && (age_edge != AGE_SAT)) begin
        age_edge <= age_edge + 1'b1;
      end
    end
  end

  // Display source is only switched at a frame boundary to avoid tearing
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      disp_sobel <= 1'b0;
    end else if (vga_frame_start) begin
      disp_sobel <= sobel_sel;
    end
  end

  // Burst FSM: issue one command strobe, ignore ready for HOLDOFF cycles,
  // then wait for the controller to return idle
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state    <= IDLE;
      hold_cnt <= '0;
      rw_en    <= 1'b0;
      rw       <= RW_WR;
      f_addr   <= '0;
      src_sel  <= SRC_NONE;
      busy     <= 1'b0;
    end else begin
      case (state)
        IDLE: begin
          if (grant) begin
            state   <= CMD;
            rw_en   <= 1'b1;
            rw      <= (win == SRC_VGA) ? RW_RD : RW_WR;
            f_addr  <= win_addr;
            src_sel <= win;
            busy    <= 1'b1;
          end
        end
        CMD: begin
          rw_en    <= 1'b0;
          hold_cnt <= '0;
          state    <= HOLD;
        end
        HOLD: begin
          if (hold_cnt == HOLD_LAST) begin
            state <= BUSY;
          end else begin
            hold_cnt <= hold_cnt + 1'b1;
          end
        end
        BUSY: begin
          if (ready) begin
            state   <= IDLE;
            src_sel <= SRC_NONE;
            busy    <= 1'b0;
          end
        end
        default: begin
          state <= IDLE;
          rw_en <= 1'b0;
          busy  <= 1'b0;
        end
      endcase
    end
  end

`ifdef ARB_STATS_EN
  // Grant counters wrap; starvation counter saturates
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      gnt_cam    <= '0;
      gnt_edge   <= '0;
      gnt_vga    <= '0;
      vga_starve <= '0;
    end else begin
      if (grant && (win == SRC_CAM))  gnt_cam  <= gnt_cam + 1'b1;
      if (grant && (win == SRC_EDGE)) gnt_edge <= gnt_edge + 1'b1;
      if (grant && (win == SRC_VGA))  gnt_vga  <= gnt_vga + 1'b1;
      if ((state == IDLE) && (vga_count == '0) && (vga_starve != 16'hFFFF)) begin
        vga_starve <= vga_starve + 1'b1;
      end
    end
  end
`endif

endmodule

// File: tb/tb_sdram_burst_arbiter.sv
// Testbench for sdram_burst_arbiter: table of single-burst vectors plus
// hand-written sequences for wrap, holdoff, idle and mid-burst reset cases.
// Expected commands are queued when stimulus is applied and checked when
// rw_en is seen.
module tb_sdram_burst_arbiter;

  logic        clk;
  logic        rst_n;
  logic        ready;
  logic [9:0]  cam_count;
  logic [9:0]  edge_count;
  logic [9:0]  vga_count;
  logic        vga_frame_start;
  logic        sobel_sel;
  logic        rw_en;
  logic        rw;
  logic [14:0] f_addr;
  logic [1:0]  src_sel;
  logic        busy;
  logic        disp_sobel;
`ifdef ARB_STATS_EN
  logic [31:0] gnt_cam, gnt_edge, gnt_vga;
  logic [15:0] vga_starve;
`endif

  sdram_burst_arbiter dut (
    .clk             (clk),
    .rst_n           (rst_n),
    .ready           (ready),
    .cam_count       (cam_count),
    .edge_count      (edge_count),
    .vga_count       (vga_count),
    .vga_frame_start (vga_frame_start),
    .sobel_sel       (sobel_sel),
    .rw_en           (rw_en),
    .rw              (rw),
    .f_addr          (f_addr),
    .src_sel         (src_sel),
    .busy            (busy),
    .disp_sobel      (disp_sobel)
`ifdef ARB_STATS_EN
    ,
    .gnt_cam         (gnt_cam),
    .gnt_edge        (gnt_edge),
    .gnt_vga         (gnt_vga),
    .vga_starve      (vga_starve)
`endif
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  typedef struct {
    logic [9:0]  cam;
    logic [9:0]  edg;
    logic [9:0]  vga;
    logic        sobel;
    logic        fs;
    logic [1:0]  src;
    logic        rw;
    logic [14:0] addr;
  } vec_t;

  typedef struct {
    logic [1:0]  src;
    logic        rw;
    logic [14:0] addr;
  } exp_t;

  exp_t exp_q[$];
  exp_t mon_e;
  vec_t vecs[20];
  int   compared;
  int   mismatched;

  // Scoreboard monitor: every command strobe must match the oldest expectation
  always @(negedge clk) begin
    if (rst_n && rw_en) begin
      compared++;
      if (exp_q.size() == 0) begin
        mismatched++;
        $display("FAIL unexpected_rw_en got src=%0d rw=%0d addr=%0d, none expected",
                 src_sel, rw, f_addr);
      end else begin
        mon_e = exp_q.pop_front();
        if (src_sel !== mon_e.src || rw !== mon_e.rw || f_addr !== mon_e.addr) begin
          mismatched++;
          $display("FAIL grant got src=%0d rw=%0d addr=%0d, expected src=%0d rw=%0d addr=%0d",
                   src_sel, rw, f_addr, mon_e.src, mon_e.rw, mon_e.addr);
        end
      end
    end
  end

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] expv);
    compared++;
    if (act !== expv) begin
      mismatched++;
      $display("FAIL %s got %0d expected %0d", name, act, expv);
    end
  endtask

  task automatic set_idle();
    cam_count  = 10'd0;
    edge_count = 10'd0;
    vga_count  = 10'd300;
    vga_frame_start = 1'b0;
  endtask

  task automatic wait_popped(input string name);
    int n = 0;
    while (exp_q.size() != 0 && n < 20) begin
      @(posedge clk); #1;
      n++;
    end
    if (exp_q.size() != 0) begin
      compared++;
      mismatched++;
      $display("FAIL %s got no rw_en expected %0d pending grant(s)", name, exp_q.size());
      exp_q.delete();
    end
  endtask

  task automatic wait_idle(input string name);
    int n = 0;
    while (busy && n < 40) begin
      @(posedge clk); #1;
      n++;
    end
    if (busy) begin
      compared++;
      mismatched++;
      $display("FAIL %s got busy=1 expected busy=0 within 40 cycles", name);
    end
  endtask

  // One complete burst; called at posedge+1 with the DUT idle
  task automatic burst(input vec_t v);
    exp_t x;
    x.src  = v.src;
    x.rw   = v.rw;
    x.addr = v.addr;
    exp_q.push_back(x);
    cam_count       = v.cam;
    edge_count      = v.edg;
    vga_count       = v.vga;
    sobel_sel       = v.sobel;
    vga_frame_start = v.fs;
    ready           = 1'b1;
    @(posedge clk); #1;
    set_idle();
    wait_popped("grant_timeout");
    wait_idle("burst_end");
  endtask

  function automatic vec_t mk(input int c, input int e, input int v, input logic s,
                              input logic fs, input logic [1:0] src, input logic r,
                              input int a);
    vec_t t;
    t.cam = 10'(c); t.edg = 10'(e); t.vga = 10'(v);
    t.sobel = s; t.fs = fs; t.src = src; t.rw = r; t.addr = 15'(a);
    return t;
  endfunction

  initial begin
    #900000;
    $display("FAIL watchdog got no finish expected completion within 90000 cycles");
    $fatal(1, "watchdog");
  end

  initial begin
    compared   = 0;
    mismatched = 0;

    // Single requesters, thresholds, aging and display-switch vectors
    vecs[0]  = mk(513,   0, 300, 0, 0, 1, 0,   0);
    vecs[1]  = mk(513,   0, 300, 0, 0, 1, 0,   1);
    vecs[2]  = mk(512,   0, 300, 0, 0, 1, 0,   2);
    vecs[3]  = mk(  0, 512, 300, 0, 0, 2, 0, 600);
    vecs[4]  = mk(600, 600,   0, 0, 0, 3, 1,   0);
    for (int i = 0; i < 7; i++) vecs[5+i] = mk(600, 600, 300, 0, 0, 1, 0, 3 + i);
    vecs[12] = mk(600, 600, 300, 0, 0, 2, 0, 601);
    vecs[13] = mk(600, 600, 249, 0, 0, 3, 1,   1);
    vecs[14] = mk(600, 600, 300, 0, 0, 1, 0,  10);
    vecs[15] = mk(  0,   0,   0, 1, 0, 3, 1,   2);
    vecs[16] = mk(  0,   0,   0, 1, 0, 3, 1, 600);
    vecs[17] = mk(  0,   0,   0, 0, 0, 3, 1, 601);
    vecs[18] = mk(  0,   0,   0, 0, 1, 3, 1, 602);
    vecs[19] = mk(  0,   0,   0, 0, 0, 3, 1,   0);

    rst_n     = 1'b0;
    ready     = 1'b0;
    sobel_sel = 1'b0;
    set_idle();
    #25;
    chk("reset_rw_en",   32'(rw_en),      0);
    chk("reset_rw",      32'(rw),         0);
    chk("reset_f_addr",  32'(f_addr),     0);
    chk("reset_src_sel", 32'(src_sel),    0);
    chk("reset_busy",    32'(busy),       0);
    chk("reset_disp",    32'(disp_sobel), 0);
    rst_n = 1'b1;
    @(posedge clk); #1;

    for (int i = 0; i < 16; i++) burst(vecs[i]);
    chk("disp_before_fs", 32'(disp_sobel), 0);

    // Standalone frame start latches sobel_sel=1 and rewinds the VGA offset
    vga_frame_start = 1'b1;
    @(posedge clk); #1;
    vga_frame_start = 1'b0;
    chk("disp_after_fs", 32'(disp_sobel), 1);

    for (int i = 16; i < 20; i++) burst(vecs[i]);
    chk("disp_after_fs_grant", 32'(disp_sobel), 0);

    // Full-frame wrap for each stream
    for (int i = 0; i < 600; i++) burst(mk(0, 0, 0, 0, 0, 3, 1, (1 + i) % 600));
    for (int i = 0; i < 600; i++) burst(mk(600, 0, 300, 0, 0, 1, 0, (11 + i) % 600));
    for (int i = 0; i < 600; i++) burst(mk(0, 600, 300, 0, 0, 2, 0, 600 + (2 + i) % 600));

    // ready low in IDLE: nothing may be issued
    cam_count = 10'd600;
    ready     = 1'b0;
    repeat (10) @(posedge clk);
    #1;
    chk("no_issue_ready_low", 32'(busy), 0);

    // Just below every request threshold: nothing may be issued
    cam_count  = 10'd511;
    edge_count = 10'd511;
    vga_count  = 10'd250;
    ready      = 1'b1;
    repeat (10) @(posedge clk);
    #1;
    chk("no_issue_thresholds", 32'(busy), 0);
    set_idle();

    // ready high through HOLD, low in BUSY for 40 cycles, then high again
    begin
      exp_t x;
      x.src = 2'd1; x.rw = 1'b0; x.addr = 15'd11;
      exp_q.push_back(x);
      cam_count = 10'd600;
      ready     = 1'b1;
      @(posedge clk); #1;
      wait_popped("hold_grant_timeout");
      @(posedge clk);
      @(posedge clk);
      #1;
      ready = 1'b0;
      chk("hold_busy",    32'(busy),    1);
      chk("hold_src_sel", 32'(src_sel), 1);
      repeat (40) @(posedge clk);
      #1;
      chk("busy_ready_low",    32'(busy),    1);
      chk("src_sel_ready_low", 32'(src_sel), 1);
      chk("rw_ready_low",      32'(rw),      0);
      x.addr = 15'd12;
      exp_q.push_back(x);
      ready = 1'b1;
      wait_popped("second_grant_timeout");
      cam_count = 10'd0;
      wait_idle("second_burst_end");
      chk("src_sel_cleared", 32'(src_sel), 0);
    end

    // Asynchronous reset in the middle of a burst
    begin
      exp_t x;
      x.src = 2'd1; x.rw = 1'b0; x.addr = 15'd13;
      exp_q.push_back(x);
      cam_count = 10'd600;
      ready     = 1'b1;
      @(posedge clk); #1;
      wait_popped("reset_burst_timeout");
      ready     = 1'b0;
      cam_count = 10'd0;
      repeat (3) @(posedge clk);
      #1;
      chk("pre_reset_busy", 32'(busy), 1);
      #2;
      rst_n = 1'b0;
      #1;
      chk("midrst_busy",    32'(busy),    0);
      chk("midrst_src_sel", 32'(src_sel), 0);
      chk("midrst_rw_en",   32'(rw_en),   0);
      chk("midrst_f_addr",  32'(f_addr),  0);
      repeat (2) @(posedge clk);
      #1;
      rst_n = 1'b1;
      @(posedge clk); #1;
    end
    burst(mk(600,   0, 300, 0, 0, 1, 0,   0));
    burst(mk(  0, 600, 300, 0, 0, 2, 0, 600));
    burst(mk(  0,   0,   0, 0, 0, 3, 1,   0));

    repeat (5) @(posedge clk);
    chk("queue_drained", 32'(exp_q.size()), 0);
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
    $finish;
  end

endmodule
